// File: rtl/pwd_lock_pkg.sv
// Shared encodings for the password verify/lock block: FSM states, HEX3 glyphs
// and the entry-validity rule used by both the check and the change paths.
package pwd_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_FAIL   = 3'd3,
        ST_LOCKED = 3'd4
    } state_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_O    = 7'b1000000;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_L    = 7'b1000111;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d != BLANK_DIGIT) && (d <= 4'd9);
    endfunction

    function automatic logic entry_valid(input logic [11:0] e);
        return digit_ok(e[3:0]) && digit_ok(e[7:4]) && digit_ok(e[11:8]);
    endfunction

endpackage

// File: rtl/pwd_verify_lock_if.sv
// Entry-side inputs from the keypad FSM and the status outputs towards LEDs/HEX3.
interface pwd_verify_lock_if;
    logic [11:0] entry_data;
    logic        entry_done;
    logic        pwd_change;
    logic        lock_now;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  tries_left;
    logic        pwd_changed;
    logic [2:0]  state_code;
    logic [6:0]  hex_status;

    modport master (
        output entry_data, entry_done, pwd_change, lock_now,
        input  unlocked, alarm, tries_left, pwd_changed, state_code, hex_status
    );

    modport slave (
        input  entry_data, entry_done, pwd_change, lock_now,
        output unlocked, alarm, tries_left, pwd_changed, state_code, hex_status
    );
endinterface

// File: rtl/sync_rise_pulse.sv
// Two-flop synchroniser plus one delay flop; emits a one-clock pulse per rising
// edge of an asynchronous level.
module sync_rise_pulse (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic pulse
);
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/pwd_verify_lock.sv
// Compares a completed 3-digit entry with the stored password and runs the
// lock / fail / lockout state machine with its hold timer and try counter.
module pwd_verify_lock
    import pwd_lock_pkg::*;
#(
    parameter logic [11:0] DEFAULT_PWD    = 12'h123,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 32,
    parameter int          FAIL_CYCLES    = 8,
    parameter int          LOCKOUT_CYCLES = 64
) (
    input  logic               clock,
    input  logic               resetn,
    pwd_verify_lock_if.slave   bus
);
    localparam int MAX_A   = (UNLOCK_CYCLES > FAIL_CYCLES) ? UNLOCK_CYCLES : FAIL_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] T_UNLOCK = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_FAIL   = TMR_W'(FAIL_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [11:0]      entry_q, entry_d;
    logic [11:0]      pwd_q, pwd_d;
    logic [1:0]       tries_q, tries_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             unlocked_q, unlocked_d;
    logic             alarm_q, alarm_d;
    logic             pwd_changed_q, pwd_changed_d;
    logic             ent_pulse;

    sync_rise_pulse u_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (bus.entry_done),
        .pulse  (ent_pulse)
    );

    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        pwd_d         = pwd_q;
        tries_d       = tries_q;
        timer_d       = timer_q;
        pwd_changed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ent_pulse) begin
                    entry_d = bus.entry_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (entry_valid(entry_q) && (entry_q == pwd_q)) begin
                    state_d = ST_OPEN;
                    tries_d = TRIES_INIT;
                    timer_d = T_UNLOCK;
                end else if (tries_q <= 2'd1) begin
                    // Last try used up: lockout, counter sits at zero until reload
                    state_d = ST_LOCKED;
                    tries_d = 2'd0;
                    timer_d = T_LOCK;
                end else begin
                    state_d = ST_FAIL;
                    tries_d = tries_q - 2'd1;
                    timer_d = T_FAIL;
                end
            end
            ST_OPEN: begin
                if (bus.lock_now || (timer_q == '0)) begin
                    state_d = ST_IDLE;
                end else if (ent_pulse && bus.pwd_change && entry_valid(bus.entry_data)) begin
                    pwd_d         = bus.entry_data;
                    pwd_changed_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_FAIL: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            ST_LOCKED: begin
                if (timer_q == '0) begin
                    tries_d = TRIES_INIT;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        unlocked_d = (state_d == ST_OPEN);
        alarm_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pwd_q         <= DEFAULT_PWD;
            tries_q       <= TRIES_INIT;
            timer_q       <= '0;
            unlocked_q    <= 1'b0;
            alarm_q       <= 1'b0;
            pwd_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwd_q         <= pwd_d;
            tries_q       <= tries_d;
            timer_q       <= timer_d;
            unlocked_q    <= unlocked_d;
            alarm_q       <= alarm_d;
            pwd_changed_q <= pwd_changed_d;
        end
    end

    // Entry capture is pure data; it is always written before CHECK reads it
    always_ff @(posedge clock) begin
        entry_q <= entry_d;
    end

    always_comb begin
        case (state_q)
            ST_OPEN:   bus.hex_status = SEG_O;
            ST_FAIL:   bus.hex_status = SEG_E;
            ST_LOCKED: bus.hex_status = SEG_L;
            default:   bus.hex_status = SEG_DASH;
        endcase
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.alarm       = alarm_q;
    assign bus.tries_left  = tries_q;
    assign bus.pwd_changed = pwd_changed_q;
    assign bus.state_code  = state_q;
endmodule
